// File: rtl/light_package.sv
// Shared light, phase and scheduler types for the intersection controllers.
// colors is unchanged from traffic_light_controller so lights stay compatible.
package light_package;

  typedef enum logic [1:0] {
    RED = 2'b00,
    YEL = 2'b01,
    GRN = 2'b10
  } colors;

  typedef enum logic [1:0] {
    NONE,
    EW_LEFT,
    EW_STR,
    NS
  } phase_t;

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    YELLOW,
    ALLRED
  } sched_state_t;

  localparam int NPH = 3;

  function automatic phase_t ph_of(input int i);
    case (i)
      0:       return EW_LEFT;
      1:       return EW_STR;
      default: return NS;
    endcase
  endfunction

endpackage

// File: rtl/phase_age_arbiter.sv
// Per-phase wait counters and oldest-waiter selection.
// Ties resolve toward the lower index: EW_LEFT, then EW_STR, then NS.
module phase_age_arbiter
  import light_package::*;
#(
  parameter int AGE_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NPH-1:0] req,
  input  phase_t         grant,
  input  phase_t         green,
  output phase_t         winner
);

  logic [AGE_W-1:0] age_q [NPH];
  logic [AGE_W-1:0] best;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPH; i++)
        age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NPH; i++) begin
        if (grant == ph_of(i))
          age_q[i] <= '0;
        else if (req[i] && green != ph_of(i)
                 && age_q[i] != '1)
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    winner = NONE;
    best   = '0;
    for (int i = 0; i < NPH; i++) begin
      if (req[i] && (winner == NONE || age_q[i] > best)) begin
        winner = ph_of(i);
        best   = age_q[i];
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Three-phase intersection sequencer with aging arbitration and preemption.
// Lights are decoded from registered state only.
module intersection_phase_scheduler
  import light_package::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MAX_GREEN  = 5,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int AGE_W      = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   e_left_sensor,
  input  logic   w_left_sensor,
  input  logic   e_straight_sensor,
  input  logic   w_straight_sensor,
  input  logic   ns_sensor,
  input  logic   emergency,
  input  phase_t emergency_phase,
  output colors  e_left_light,
  output colors  w_left_light,
  output colors  e_str_light,
  output colors  w_str_light,
  output colors  ns_light,
  output phase_t active_phase,
  output logic   busy
);

  localparam int CW = 8;
  localparam logic [CW-1:0] MIN_C = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_C = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] AR_C  = CW'(ALLRED_CYC - 1);

  sched_state_t   state_q, state_d;
  phase_t         phase_q, phase_d;
  phase_t         grant, winner, green_ph;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NPH-1:0] req;
  logic           em, em_hold, own_req, other_req;
  colors          lt_c;

  assign req = {ns_sensor,
                e_straight_sensor | w_straight_sensor,
                e_left_sensor | w_left_sensor};
  assign em  = emergency && (emergency_phase != NONE);
  assign green_ph = (state_q == GREEN) ? phase_q : NONE;

  phase_age_arbiter #(.AGE_W(AGE_W)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .green  (green_ph),
    .winner (winner)
  );

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    unique case (phase_q)
      EW_LEFT: begin
        own_req   = req[0];
        other_req = req[1] | req[2];
      end
      EW_STR: begin
        own_req   = req[1];
        other_req = req[0] | req[2];
      end
      NS: begin
        own_req   = req[2];
        other_req = req[0] | req[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter saturates so a long held green never wraps below the limits.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    grant   = NONE;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    em_hold = em && (emergency_phase == phase_q);
    unique case (state_q)
      IDLE: begin
        grant = em ? emergency_phase : winner;
        cnt_d = '0;
        if (grant != NONE) begin
          state_d = GREEN;
          phase_d = grant;
        end
      end
      GREEN: begin
        if ((em && !em_hold) ||
            (!em_hold && cnt_q >= MIN_C && !own_req) ||
            (!em_hold && cnt_q >= MAX_C && other_req)) begin
          state_d = YELLOW;
          cnt_d   = '0;
        end
      end
      YELLOW: begin
        if (cnt_q == YEL_C) begin
          state_d = ALLRED;
          phase_d = NONE;
          cnt_d   = '0;
        end
      end
      ALLRED: begin
        if (cnt_q == AR_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = NONE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lt_c = RED;
    unique case (1'b1)
      state_q == GREEN:  lt_c = GRN;
      state_q == YELLOW: lt_c = YEL;
      default:           lt_c = RED;
    endcase
  end

  assign e_left_light = (phase_q == EW_LEFT) ? lt_c : RED;
  assign w_left_light = (phase_q == EW_LEFT) ? lt_c : RED;
  assign e_str_light  = (phase_q == EW_STR)  ? lt_c : RED;
  assign w_str_light  = (phase_q == EW_STR)  ? lt_c : RED;
  assign ns_light     = (phase_q == NS)      ? lt_c : RED;

  assign busy = (state_q == GREEN) || (state_q == YELLOW);
  assign active_phase = busy ? phase_q : NONE;

endmodule
